mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// MEM stage handshake and data bundle: EXE->MEM bus, SRAM read data,
// WB back-pressure, MEM->WB bus and MEM->ID forwarding.
interface mem_stage_if;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_value;

    // Surrounding pipeline side: drives EXE/WB/SRAM inputs, observes MEM outputs
    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value
    );

    // MEM stage side
    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest, ms_to_ds_value
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, aligns and extends
// load data from the data SRAM, and keeps the read word stable across WB
// stalls (the SRAM only presents it on the cycle right after acceptance).
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  ms_if
);
    logic        r_ms_valid;
    logic [75:0] r_bus;
    logic        r_fresh;
    logic        r_hold_valid;
    logic [31:0] r_hold;

    logic        w_allowin;
    logic        w_accept;
    logic        w_leave;
    logic        w_capture;
    logic [4:0]  w_ld_op;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic [31:0] w_word;
    logic [31:0] w_final;
    logic        w_fwd_en;

    // Select byte/half by address and extend; ld_op==0 falls through to ld.w
    function automatic logic [31:0] load_extend(input logic [4:0]  op,
                                                input logic [1:0]  addr,
                                                input logic [31:0] word);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (addr)
            2'b00:   v_byte = word[7:0];
            2'b01:   v_byte = word[15:8];
            2'b10:   v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = addr[1] ? word[31:16] : word[15:0];
        if (op[0])      v_res = {{24{v_byte[7]}}, v_byte};
        else if (op[1]) v_res = {{16{v_half[15]}}, v_half};
        else if (op[3]) v_res = {24'd0, v_byte};
        else if (op[4]) v_res = {16'd0, v_half};
        else            v_res = word;
        return v_res;
    endfunction

    assign w_allowin = !r_ms_valid || ms_if.ws_allowin;
    assign w_accept  = ms_if.es_to_ms_valid && w_allowin;
    assign w_leave   = r_ms_valid && ms_if.ws_allowin;
    // Read data is only live on the fresh cycle; save it if WB is stalling
    assign w_capture = r_fresh && r_ms_valid && !ms_if.ws_allowin;

    assign w_ld_op        = r_bus[75:71];
    assign w_res_from_mem = r_bus[70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_alu_result   = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    assign w_word   = r_hold_valid ? r_hold : ms_if.data_sram_rdata;
    assign w_final  = w_res_from_mem ? load_extend(w_ld_op, w_alu_result[1:0], w_word)
                                     : w_alu_result;
    assign w_fwd_en = r_ms_valid && w_gr_we;

    assign ms_if.ms_allowin     = w_allowin;
    assign ms_if.ms_to_ws_valid = r_ms_valid;
    assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final, w_pc};
    assign ms_if.ms_to_ds_dest  = w_fwd_en ? w_dest  : 5'd0;
    assign ms_if.ms_to_ds_value = w_fwd_en ? w_final : 32'd0;

    // Control state: valid, fresh-data flag and hold-valid flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid   <= 1'b0;
            r_fresh      <= 1'b0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_allowin)
                r_ms_valid <= ms_if.es_to_ms_valid;
            r_fresh <= w_accept;
            if (w_accept)
                r_hold_valid <= 1'b0;
            else if (w_leave)
                r_hold_valid <= 1'b0;
            else if (w_capture)
                r_hold_valid <= 1'b1;
        end
    end

    // Data registers: instruction bus and held read word (no reset needed)
    always_ff @(posedge clk) begin
        if (w_accept)
            r_bus <= ms_if.es_to_ms_bus;
        if (w_capture)
            r_hold <= ms_if.data_sram_rdata;
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// run against a transaction-level model of the stage.
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .ms_if  (ifc.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: the instruction held in MEM and the word its load returned
    logic        m_valid = 1'b0;
    logic [75:0] m_bus   = '0;
    logic        m_fresh = 1'b0;
    logic [31:0] m_word  = '0;
    logic        e_allowin;

    function automatic logic [75:0] mk_bus(input logic [4:0] op, input logic rfm,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {op, rfm, we, dest, alu, pc};
    endfunction

    // Reference load: shift the word down, mask, and sign-adjust arithmetically
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        logic [1:0]  a;
        a = addr[1:0];
        if (op == 5'd1 || op == 5'd8) begin
            v = (word >> (8 * a)) & 32'hFF;
            if (op == 5'd1 && v >= 32'd128) v = v - 32'd256;
        end else if (op == 5'd2 || op == 5'd16) begin
            v = (word >> (16 * a[1])) & 32'hFFFF;
            if (op == 5'd2 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_final();
        if (m_bus[70]) return ref_load(m_bus[75:71], m_bus[63:32], m_word);
        return m_bus[63:32];
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle
    task automatic cyc(input logic ev, input logic [75:0] b, input logic ws, input logic [31:0] rd);
        @(negedge clk);
        ifc.es_to_ms_valid  = ev;
        ifc.es_to_ms_bus    = b;
        ifc.ws_allowin      = ws;
        ifc.data_sram_rdata = rd;
        if (m_fresh) m_word = rd;
        e_allowin = !m_valid || ws;
        #1;
    endtask

    // Advance the model across the rising edge
    task automatic adv();
        @(posedge clk);
        if (e_allowin) begin
            m_valid = ifc.es_to_ms_valid;
            m_fresh = ifc.es_to_ms_valid;
            if (ifc.es_to_ms_valid) m_bus = ifc.es_to_ms_bus;
        end else begin
            m_fresh = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ifc.es_to_ms_valid = 1'b0; ifc.es_to_ms_bus = '0;
        ifc.ws_allowin = 1'b0; ifc.data_sram_rdata = '0;
        #2;
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", ifc.ms_to_ws_valid); end
        n_checks++; if (ifc.ms_allowin !== 1'b1) begin n_errors++; $display("FAIL reset_allowin got %b want 1", ifc.ms_allowin); end
        n_checks++; if (ifc.ms_to_ds_dest !== 5'd0) begin n_errors++; $display("FAIL reset_dest got %h want 0", ifc.ms_to_ds_dest); end
        n_checks++; if (ifc.ms_to_ds_value !== 32'd0) begin n_errors++; $display("FAIL reset_value got %h want 0", ifc.ms_to_ds_value); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_ld_b();
        cyc(1'b1, mk_bus(5'd1, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0000), 1'b1, 32'h0);
        adv();
        cyc(1'b0, '0, 1'b1, 32'h80FF_1234);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL ld_b_result got %h want ffffff80", ifc.ms_to_ws_bus[63:32]); end
        n_checks++; if (ifc.ms_to_ds_dest !== 5'd7) begin n_errors++; $display("FAIL ld_b_fwd_dest got %0d want 7", ifc.ms_to_ds_dest); end
        n_checks++; if (ifc.ms_to_ds_value !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL ld_b_fwd_value got %h want ffffff80", ifc.ms_to_ds_value); end
        adv();
    endtask

    task automatic test_ld_h();
        cyc(1'b1, mk_bus(5'd16, 1'b1, 1'b1, 5'd3, 32'h0000_2002, 32'h1C00_0004), 1'b1, 32'h0);
        adv();
        cyc(1'b1, mk_bus(5'd2, 1'b1, 1'b1, 5'd4, 32'h0000_2002, 32'h1C00_0008), 1'b1, 32'h8001_7FFF);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'h0000_8001) begin n_errors++; $display("FAIL ld_hu_result got %h want 00008001", ifc.ms_to_ws_bus[63:32]); end
        adv();
        cyc(1'b0, '0, 1'b1, 32'h8001_7FFF);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hFFFF_8001) begin n_errors++; $display("FAIL ld_h_result got %h want ffff8001", ifc.ms_to_ws_bus[63:32]); end
        adv();
    endtask

    task automatic test_stall();
        logic [75:0] nxt;
        nxt = mk_bus(5'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0077, 32'h1C00_0010);
        cyc(1'b1, mk_bus(5'd4, 1'b1, 1'b1, 5'd5, 32'h0000_3000, 32'h1C00_000C), 1'b1, 32'h0);
        adv();
        cyc(1'b1, nxt, 1'b0, 32'hDEAD_BEEF);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL stall_c0 got %h want deadbeef", ifc.ms_to_ws_bus[63:32]); end
        n_checks++; if (ifc.ms_allowin !== 1'b0) begin n_errors++; $display("FAIL stall_allowin got %b want 0", ifc.ms_allowin); end
        adv();
        for (int i = 1; i < 3; i++) begin
            cyc(1'b1, nxt, 1'b0, 32'h0);
            n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL stall_c%0d got %h want deadbeef", i, ifc.ms_to_ws_bus[63:32]); end
            n_checks++; if (ifc.ms_to_ws_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid_c%0d got %b want 1", i, ifc.ms_to_ws_valid); end
            adv();
        end
        // WB releases; the waiting instruction is accepted in the same cycle
        cyc(1'b1, nxt, 1'b1, 32'h0);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL stall_leave got %h want deadbeef", ifc.ms_to_ws_bus[63:32]); end
        n_checks++; if (ifc.ms_allowin !== 1'b1) begin n_errors++; $display("FAIL stall_leave_allowin got %b want 1", ifc.ms_allowin); end
        adv();
        cyc(1'b0, '0, 1'b1, 32'h1234_5678);
        n_checks++; if (ifc.ms_to_ws_bus !== {1'b1, 5'd9, 32'h0000_0077, 32'h1C00_0010}) begin n_errors++; $display("FAIL stall_next_bus got %h want %h", ifc.ms_to_ws_bus, {1'b1, 5'd9, 32'h0000_0077, 32'h1C00_0010}); end
        adv();
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, mk_bus(5'd0, 1'b0, 1'b1, 5'd1, 32'h0000_0005, 32'h1C00_0020), 1'b1, 32'hFFFF_FFFF);
        adv();
        cyc(1'b1, mk_bus(5'd8, 1'b1, 1'b1, 5'd2, 32'h0000_0001, 32'h1C00_0024), 1'b1, 32'hFFFF_FFFF);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'h5) begin n_errors++; $display("FAIL b2b_alu got %h want 5", ifc.ms_to_ws_bus[63:32]); end
        adv();
        cyc(1'b0, '0, 1'b1, 32'h0000_AB00);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'hAB) begin n_errors++; $display("FAIL b2b_ldbu got %h want ab", ifc.ms_to_ws_bus[63:32]); end
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid got %b want 1", ifc.ms_to_ws_valid); end
        adv();
    endtask

    task automatic test_no_write();
        cyc(1'b1, mk_bus(5'd0, 1'b0, 1'b0, 5'd11, 32'h0000_1234, 32'h1C00_0030), 1'b1, 32'h0);
        adv();
        cyc(1'b0, '0, 1'b1, 32'hCAFE_F00D);
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b1) begin n_errors++; $display("FAIL nowr_valid got %b want 1", ifc.ms_to_ws_valid); end
        n_checks++; if (ifc.ms_to_ds_dest !== 5'd0) begin n_errors++; $display("FAIL nowr_dest got %0d want 0", ifc.ms_to_ds_dest); end
        n_checks++; if (ifc.ms_to_ds_value !== 32'd0) begin n_errors++; $display("FAIL nowr_value got %h want 0", ifc.ms_to_ds_value); end
        adv();
        cyc(1'b0, '0, 1'b1, 32'h0);
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid got %b want 0", ifc.ms_to_ws_valid); end
        adv();
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [75:0] b;
        logic [31:0] ef;
        logic [4:0]  ed;
        logic [31:0] ev;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: op = 5'd0;  1: op = 5'd1;  2: op = 5'd2;
                3: op = 5'd4;  4: op = 5'd8;  default: op = 5'd16;
            endcase
            b = mk_bus(op, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       5'($urandom), $urandom, $urandom);
            cyc(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) != 0), $urandom);
            ef = ref_final();
            ed = (m_valid && m_bus[69]) ? m_bus[68:64] : 5'd0;
            ev = (m_valid && m_bus[69]) ? ef : 32'd0;
            n_checks++; if (ifc.ms_to_ws_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, ifc.ms_to_ws_valid, m_valid); end
            n_checks++; if (ifc.ms_allowin !== e_allowin) begin n_errors++; $display("FAIL rnd_allowin cyc %0d got %b want %b", i, ifc.ms_allowin, e_allowin); end
            n_checks++; if (ifc.ms_to_ds_dest !== ed) begin n_errors++; $display("FAIL rnd_fwd_dest cyc %0d got %h want %h", i, ifc.ms_to_ds_dest, ed); end
            n_checks++; if (ifc.ms_to_ds_value !== ev) begin n_errors++; $display("FAIL rnd_fwd_value cyc %0d got %h want %h", i, ifc.ms_to_ds_value, ev); end
            if (m_valid) begin
                n_checks++;
                if (ifc.ms_to_ws_bus !== {m_bus[69], m_bus[68:64], ef, m_bus[31:0]}) begin
                    n_errors++;
                    $display("FAIL rnd_bus cyc %0d got %h want %h", i, ifc.ms_to_ws_bus, {m_bus[69], m_bus[68:64], ef, m_bus[31:0]});
                end
            end
            adv();
        end
        cyc(1'b0, '0, 1'b1, 32'h0);
        adv();
    endtask

    task automatic test_reset_mid_stall();
        cyc(1'b1, mk_bus(5'd4, 1'b1, 1'b1, 5'd6, 32'h0000_4000, 32'h1C00_0040), 1'b1, 32'h0);
        adv();
        cyc(1'b0, '0, 1'b0, 32'h1111_2222);
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b1) begin n_errors++; $display("FAIL rst_pre_valid got %b want 1", ifc.ms_to_ws_valid); end
        adv();
        cyc(1'b0, '0, 1'b0, 32'h0);
        resetn = 1'b0;
        #1;
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid got %b want 0", ifc.ms_to_ws_valid); end
        n_checks++; if (ifc.ms_allowin !== 1'b1) begin n_errors++; $display("FAIL rst_async_allowin got %b want 1", ifc.ms_allowin); end
        n_checks++; if (ifc.ms_to_ds_dest !== 5'd0) begin n_errors++; $display("FAIL rst_async_dest got %0d want 0", ifc.ms_to_ds_dest); end
        adv();
        m_valid = 1'b0; m_fresh = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cyc(1'b0, '0, 1'b0, 32'h0);
        n_checks++; if (ifc.ms_allowin !== 1'b1) begin n_errors++; $display("FAIL rst_post_allowin got %b want 1", ifc.ms_allowin); end
        n_checks++; if (ifc.ms_to_ws_valid !== 1'b0) begin n_errors++; $display("FAIL rst_post_valid got %b want 0", ifc.ms_to_ws_valid); end
        adv();
        // First accept after release, with a stall: fresh data must be held
        cyc(1'b1, mk_bus(5'd1, 1'b1, 1'b1, 5'd8, 32'h0000_5002, 32'h1C00_0044), 1'b0, 32'h0);
        adv();
        cyc(1'b0, '0, 1'b0, 32'h0055_0000);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'h55) begin n_errors++; $display("FAIL rst_first_ld got %h want 55", ifc.ms_to_ws_bus[63:32]); end
        adv();
        cyc(1'b0, '0, 1'b1, 32'h00AA_0000);
        n_checks++; if (ifc.ms_to_ws_bus[63:32] !== 32'h55) begin n_errors++; $display("FAIL rst_first_hold got %h want 55", ifc.ms_to_ws_bus[63:32]); end
        adv();
    endtask

    initial begin
        test_reset();
        test_ld_b();
        test_ld_h();
        test_stall();
        test_back_to_back();
        test_no_write();
        test_random();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
